// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the player-input path:
//   user_event_t  3-bit event code carried to the game logic
//   BTN_*         bit positions of each button inside the raw button vector
//   NUM_BTN       number of player buttons
// -----------------------------------------------------------------------------
package tetris_pkg;

  typedef enum logic [2:0] {
    EV_LEFT     = 3'd0,
    EV_RIGHT    = 3'd1,
    EV_DOWN     = 3'd2,
    EV_ROTATE   = 3'd3,
    EV_NEW_GAME = 3'd4
  } user_event_t;

  localparam int BTN_LEFT     = 0;
  localparam int BTN_RIGHT    = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_ROTATE   = 3;
  localparam int BTN_NEW_GAME = 4;
  localparam int NUM_BTN      = 5;

endpackage

// File: rtl/user_event_gen_if.sv
// -----------------------------------------------------------------------------
// user_event_if
// Event handshake between the input block and the game logic.
//   user_event  head-of-queue event code (meaningful only while ready=1)
//   ready       an event is available
//   rd_req      consumer takes the head event this cycle
// master = event producer, slave = event consumer.
// -----------------------------------------------------------------------------
interface user_event_if;
  import tetris_pkg::*;

  user_event_t user_event;
  logic        ready;
  logic        rd_req;

  modport master (output user_event, output ready, input rd_req);
  modport slave  (input user_event, input ready, output rd_req);
endinterface

// File: rtl/user_event_gen_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One button: 2-flop synchroniser, debounce, press-edge pulse and optional
// auto-repeat.
//   clk_i, rst_n_i  clock, async active-low reset
//   btn_i           raw asynchronous level, 1 = pressed
//   pulse_o         registered one-cycle pulse per press / auto-repeat
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 8000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic          sync1, sync2;
  logic          sync_valid1, sync_valid2;
  logic          armed;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic          rep_active, rep_first_done;
  logic [RW-1:0] rep_cnt;
  logic          accept, rep_hit;

  // The synchronised level has differed from the stable level long enough.
  assign accept  = (sync2 != stable) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rep_hit = rep_first_done ? (rep_cnt == RW'(REPEAT_PERIOD - 1))
                                  : (rep_cnt == RW'(REPEAT_DELAY - 1));

  // sync_valid marks when sync2 reflects the real input after reset. The
  // button is only armed once it has been seen released, so a button held
  // through reset release produces nothing until it is let go and re-pressed.
  // A level change (accept) takes priority over a repeat firing in the same
  // cycle, so a release always suppresses any further repeat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      sync_valid1    <= 1'b0;
      sync_valid2    <= 1'b0;
      armed          <= 1'b0;
      stable         <= 1'b0;
      db_cnt         <= '0;
      rep_active     <= 1'b0;
      rep_first_done <= 1'b0;
      rep_cnt        <= '0;
      pulse_o        <= 1'b0;
    end else begin
      sync1       <= btn_i;
      sync2       <= sync1;
      sync_valid1 <= 1'b1;
      sync_valid2 <= sync_valid1;
      if (sync_valid2 && !sync2)
        armed <= 1'b1;

      if (sync2 == stable || accept)
        db_cnt <= '0;
      else
        db_cnt <= db_cnt + 1'b1;

      pulse_o <= 1'b0;
      if (accept) begin
        stable         <= sync2;
        rep_cnt        <= '0;
        rep_first_done <= 1'b0;
        rep_active     <= sync2 && armed && REPEAT_EN;
        pulse_o        <= sync2 && armed;
      end else if (rep_active) begin
        if (rep_hit) begin
          rep_cnt        <= '0;
          rep_first_done <= 1'b1;
          pulse_o        <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/user_event_gen.sv
// -----------------------------------------------------------------------------
// user_event_gen
// Converts raw player buttons into the queued user event stream.
//   clk_i     system clock
//   rst_n_i   async reset, active-low; discards all pending and queued events
//   btn_i     raw levels [0]left [1]right [2]down [3]rotate [4]new_game
//   evt       event handshake (master): user_event / ready / rd_req
// Each button feeds a pending flag; one flag per cycle is pushed into a
// show-ahead FIFO in priority new_game > rotate > down > left > right.
// -----------------------------------------------------------------------------
module user_event_gen
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 8000000,
  parameter int REPEAT_PERIOD   = 2000000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_BTN-1:0] btn_i,
  user_event_if.master       evt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] grant;
  user_event_t        push_ev;
  user_event_t        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, push, pop;

  // Only the movement buttons auto-repeat.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (i <= BTN_DOWN)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .btn_i   (btn_i[i]),
      .pulse_o (pulse[i])
    );
  end

  // Fixed-priority pick among the pending flags.
  always_comb begin
    grant   = '0;
    push_ev = EV_LEFT;
    if (pending[BTN_NEW_GAME]) begin
      grant[BTN_NEW_GAME] = 1'b1;
      push_ev             = EV_NEW_GAME;
    end else if (pending[BTN_ROTATE]) begin
      grant[BTN_ROTATE] = 1'b1;
      push_ev           = EV_ROTATE;
    end else if (pending[BTN_DOWN]) begin
      grant[BTN_DOWN] = 1'b1;
      push_ev         = EV_DOWN;
    end else if (pending[BTN_LEFT]) begin
      grant[BTN_LEFT] = 1'b1;
      push_ev         = EV_LEFT;
    end else if (pending[BTN_RIGHT]) begin
      grant[BTN_RIGHT] = 1'b1;
      push_ev          = EV_RIGHT;
    end
  end

  // A full FIFO still accepts a push when the head is popped the same cycle.
  assign full = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop  = evt.rd_req && (count != '0);
  assign push = (|pending) && (!full || pop);

  // Pending flags clear on push but a fresh pulse re-sets them in the same
  // cycle; a pulse landing on an already-set flag simply merges into it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= EV_LEFT;
    end else begin
      pending <= (pending & ~(push ? grant : '0)) | pulse;
      if (push) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt.user_event = mem[rd_ptr];
  assign evt.ready      = (count != '0);

endmodule

// File: tb/tb_user_event_gen.sv
// -----------------------------------------------------------------------------
// tb_user_event_gen
// Scoreboard bench for user_event_gen with small timing parameters.
// -----------------------------------------------------------------------------
module tb_user_event_gen;
  import tetris_pkg::*;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_LEFT = 5'b00001;
  localparam logic [4:0] B_RGT  = 5'b00010;
  localparam logic [4:0] B_DOWN = 5'b00100;
  localparam logic [4:0] B_ROT  = 5'b01000;
  localparam logic [4:0] B_NG   = 5'b10000;

  typedef struct {
    user_event_t ev;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  user_event_if evt_if ();

  user_event_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .btn_i   (btn),
    .evt     (evt_if)
  );

  // Free-running clock and cycle counter used as the timing reference.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted read is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && evt_if.ready && evt_if.rd_req) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event: got %0d at cycle %0d, none expected",
                 evt_if.user_event, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (evt_if.user_event !== e.ev || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("[TB] FAIL event_match: got ev %0d at cycle %0d, expected ev %0d at cycle %0d",
                   evt_if.user_event, cyc, e.ev, e.cyc);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] b, input int n);
    btn = b;
    waitCycles(n);
  endtask

  task automatic expectEvent(input user_event_t ev, input int c);
    exp_t e;
    e.ev  = ev;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int c;
    rst_n         = 1'b0;
    btn           = B_NONE;
    evt_if.rd_req = 1'b0;
    waitCycles(3);
    checkOutput("reset_ready", int'(evt_if.ready), 0);
    checkOutput("reset_event", int'(evt_if.user_event), 0);
    rst_n = 1'b1;
    waitCycles(5);

    // 1: short glitch ignored, then one clean press.
    $display("[TB] test 1 glitch then press");
    evt_if.rd_req = 1'b1;
    applyStimulus(B_LEFT, 3);
    applyStimulus(B_NONE, 15);
    c = cyc;
    expectEvent(EV_LEFT, c + 8);
    applyStimulus(B_LEFT, 12);
    applyStimulus(B_NONE, 20);
    checkOutput("t1_sb_empty", sb.size(), 0);

    // 2: held down auto-repeats after 20, then every 8 cycles.
    $display("[TB] test 2 auto-repeat");
    c = cyc;
    expectEvent(EV_DOWN, c + 8);
    expectEvent(EV_DOWN, c + 28);
    expectEvent(EV_DOWN, c + 36);
    expectEvent(EV_DOWN, c + 44);
    expectEvent(EV_DOWN, c + 52);
    expectEvent(EV_DOWN, c + 60);
    applyStimulus(B_DOWN, 60);
    applyStimulus(B_NONE, 30);
    checkOutput("t2_sb_empty", sb.size(), 0);

    // 3: rotate never repeats.
    $display("[TB] test 3 rotate hold");
    c = cyc;
    expectEvent(EV_ROTATE, c + 8);
    applyStimulus(B_ROT, 100);
    applyStimulus(B_NONE, 20);
    checkOutput("t3_sb_empty", sb.size(), 0);

    // 4: simultaneous presses are queued in priority order.
    $display("[TB] test 4 simultaneous presses");
    evt_if.rd_req = 1'b0;
    applyStimulus(B_LEFT | B_ROT | B_NG, 10);
    applyStimulus(B_NONE, 15);
    checkOutput("t4_ready", int'(evt_if.ready), 1);
    checkOutput("t4_head", int'(evt_if.user_event), int'(EV_NEW_GAME));
    expectEvent(EV_NEW_GAME, -1);
    expectEvent(EV_ROTATE, -1);
    expectEvent(EV_LEFT, -1);
    evt_if.rd_req = 1'b1;
    waitCycles(10);
    checkOutput("t4_sb_empty", sb.size(), 0);

    // 5: full FIFO holds the fifth press pending until a pop frees a slot.
    $display("[TB] test 5 full fifo");
    evt_if.rd_req = 1'b0;
    applyStimulus(B_LEFT, 6);
    applyStimulus(B_NONE, 12);
    applyStimulus(B_DOWN, 6);
    applyStimulus(B_NONE, 12);
    applyStimulus(B_ROT, 6);
    applyStimulus(B_NONE, 12);
    applyStimulus(B_NG, 6);
    applyStimulus(B_NONE, 12);
    applyStimulus(B_RGT, 6);
    applyStimulus(B_NONE, 14);
    checkOutput("t5_full_ready", int'(evt_if.ready), 1);
    checkOutput("t5_full_head", int'(evt_if.user_event), int'(EV_LEFT));
    expectEvent(EV_LEFT, -1);
    expectEvent(EV_DOWN, -1);
    expectEvent(EV_ROTATE, -1);
    expectEvent(EV_NEW_GAME, -1);
    expectEvent(EV_RIGHT, -1);
    evt_if.rd_req = 1'b1;
    waitCycles(1);
    evt_if.rd_req = 1'b0;
    waitCycles(2);
    checkOutput("t5_head_after_pop", int'(evt_if.user_event), int'(EV_DOWN));
    evt_if.rd_req = 1'b1;
    waitCycles(10);
    checkOutput("t5_sb_empty", sb.size(), 0);
    checkOutput("t5_drained_ready", int'(evt_if.ready), 0);

    // 6: reset mid-hold discards the queue; held button stays silent.
    $display("[TB] test 6 reset mid-hold");
    evt_if.rd_req = 1'b0;
    applyStimulus(B_LEFT, 32);
    checkOutput("t6_queued_ready", int'(evt_if.ready), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_ready", int'(evt_if.ready), 0);
    checkOutput("t6_reset_event", int'(evt_if.user_event), 0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(30);
    checkOutput("t6_held_no_event", int'(evt_if.ready), 0);
    evt_if.rd_req = 1'b1;
    applyStimulus(B_NONE, 15);
    c = cyc;
    expectEvent(EV_LEFT, c + 8);
    applyStimulus(B_LEFT, 10);
    applyStimulus(B_NONE, 20);
    checkOutput("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
